// File: rtl/dmem_store_responder_if.sv
// Data-memory port bundle between a MIPS core (or bench) and the store responder.
// Carries the core read/write bus, the store-log drain handshake and checker status.
// master = core/reader side, slave = responder side.
interface dmem_store_responder_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        log_valid;
  logic        log_ready;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic        overflow;
  logic [15:0] store_count;
  logic        done;
  logic        pass;
  logic        fail;

  modport master (
    output memwrite, dataadr, writedata, log_ready,
    input  readdata, log_valid, log_addr, log_data, overflow, store_count,
           done, pass, fail
  );

  modport slave (
    input  memwrite, dataadr, writedata, log_ready,
    output readdata, log_valid, log_addr, log_data, overflow, store_count,
           done, pass, fail
  );
endinterface

// File: rtl/dmem_store_responder.sv
// Data-RAM responder for the core memory port, store log FIFO and pass/fail checker.
// Latency: readdata combinational; stores land at the edge; log head is fall-through.
// Backpressure: log drains on log_valid&&log_ready; a push into a full log with no pop
// is dropped and sets the sticky overflow flag.
// Ports: i_clk (rising edge), i_reset (async, active-low), bus (slave modport).
module dmem_store_responder #(
  parameter int          WORDS      = 64,
  parameter int          DEPTH      = 8,
  parameter logic [31:0] DONE_ADDR  = 32'd84,
  parameter logic [31:0] DONE_VALUE = 32'd7,
  parameter logic [31:0] ALLOW_ADDR = 32'd80
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  dmem_store_responder_if.slave bus
);
  localparam int AW = $clog2(WORDS);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

  logic [31:0]   r_ram      [WORDS];
  logic [31:0]   r_log_addr [DEPTH];
  logic [31:0]   r_log_data [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_overflow;
  logic [15:0]   r_store_count;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_done;
  logic          r_pass;
  logic          r_fail;

  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic          w_aligned;
  logic          w_ram_we;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  // ---------------- data RAM (not reset, survives a mid-run reset) ----------------
  assign w_idx      = bus.dataadr[AW+1:2];
  assign w_in_range = bus.dataadr < 32'(4 * WORDS);
  assign w_aligned  = bus.dataadr[1:0] == 2'b00;
  assign w_ram_we   = bus.memwrite && w_in_range && w_aligned;

  assign bus.readdata = w_in_range ? r_ram[w_idx] : 32'h0;

  always_ff @(posedge i_clk) begin
    if (w_ram_we) r_ram[w_idx] <= bus.writedata;
  end

  // ---------------- store log FIFO ----------------
  assign w_empty = r_count == '0;
  assign w_full  = r_count == (PW+1)'(DEPTH);
  assign w_pop   = !w_empty && bus.log_ready;
  // A full log still accepts a push when the head leaves in the same cycle.
  assign w_push  = bus.memwrite && (!w_full || w_pop);

  assign bus.log_valid = !w_empty;
  assign bus.log_addr  = w_empty ? 32'h0 : r_log_addr[r_rd_ptr];
  assign bus.log_data  = w_empty ? 32'h0 : r_log_data[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_log_addr[r_wr_ptr] <= bus.dataadr;
      r_log_data[r_wr_ptr] <= bus.writedata;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_store_count <= 16'h0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (bus.memwrite && w_full && !w_pop) r_overflow <= 1'b1;
      if (bus.memwrite && (r_store_count != 16'hFFFF))
        r_store_count <= r_store_count + 16'd1;
    end
  end

  assign bus.overflow    = r_overflow;
  assign bus.store_count = r_store_count;

  // ---------------- pass/fail checker ----------------
  always_comb begin
    w_state_nxt = r_state;
    if (bus.memwrite && (r_state == ST_RUN)) begin
      if (bus.dataadr == DONE_ADDR) begin
        if (bus.writedata == DONE_VALUE) w_state_nxt = ST_PASS;
        else                             w_state_nxt = ST_FAIL;
      end else if (!w_aligned) begin
        w_state_nxt = ST_FAIL;
      end else if (bus.dataadr != ALLOW_ADDR) begin
        w_state_nxt = ST_FAIL;
      end
    end
  end

  // Status flags decode the next state so they rise the cycle after the deciding store.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_RUN;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_state_nxt != ST_RUN;
      r_pass  <= w_state_nxt == ST_PASS;
      r_fail  <= w_state_nxt == ST_FAIL;
    end
  end

  assign bus.done = r_done;
  assign bus.pass = r_pass;
  assign bus.fail = r_fail;
endmodule

// File: tb/tb_dmem_store_responder.sv
// Self-checking bench for dmem_store_responder: directed scenarios plus a randomized
// run, all compared against a queue/array reference model of the store rules.
module tb_dmem_store_responder;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_store_responder_if bus();

  dmem_store_responder dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: RAM words written so far, log as a queue, checker as a small int.
  logic [31:0] m_ram   [64];
  bit          m_known [64];
  logic [63:0] m_q     [$];
  bit          m_ovf;
  logic [15:0] m_cnt;
  int          m_state;   // 0 running, 1 passed, 2 failed

  task automatic m_reset();
    m_q.delete();
    m_ovf   = 1'b0;
    m_cnt   = 16'h0;
    m_state = 0;
  endtask

  task automatic model_edge(input bit we, input logic [31:0] a, input logic [31:0] d,
                            input bit rdy);
    bit pop;
    pop = rdy && (m_q.size() > 0);
    if (we) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (a < 32'd256 && a % 4 == 0) begin
        m_ram[a/4]   = d;
        m_known[a/4] = 1'b1;
      end
      if (m_state == 0) begin
        if (a == 32'd84)      m_state = (d == 32'd7) ? 1 : 2;
        else if (a != 32'd80) m_state = 2;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (we) begin
      if (m_q.size() < 8) m_q.push_back({a, d});
      else                m_ovf = 1'b1;
    end
  endtask

  // One clock: inputs set between edges, model advanced at the edge, back at negedge.
  task automatic drive(input bit we, input logic [31:0] a, input logic [31:0] d,
                       input bit rdy);
    bus.memwrite  = we;
    bus.dataadr   = a;
    bus.writedata = d;
    bus.log_ready = rdy;
    @(posedge clk);
    model_edge(we, a, d, rdy);
    @(negedge clk);
    bus.memwrite  = 1'b0;
    bus.log_ready = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] v);
    bus.memwrite = 1'b0;
    bus.dataadr  = a;
    #1;
    v = bus.readdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.memwrite  = 1'b0;
    bus.log_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.memwrite = 1'b1; bus.dataadr = 32'd84; bus.writedata = 32'd7; bus.log_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.log_valid !== 1'b0) begin n_err++; $display("FAIL reset_log_valid: got %b want 0", bus.log_valid); end
    n_cmp++; if (bus.store_count !== 16'h0) begin n_err++; $display("FAIL reset_store_count: got %0d want 0", bus.store_count); end
    n_cmp++; if ({bus.done, bus.pass, bus.fail} !== 3'b000) begin n_err++; $display("FAIL reset_status: got %b want 000", {bus.done, bus.pass, bus.fail}); end
    n_cmp++; if ({bus.log_addr, bus.log_data} !== 64'h0) begin n_err++; $display("FAIL reset_log_head: got %h want 0", {bus.log_addr, bus.log_data}); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    bus.memwrite = 1'b0;
    rst_n = 1'b1;
    m_reset();
    m_known[21] = 1'b0;
  endtask

  task automatic test_pass();
    logic [31:0] v;
    do_reset();
    drive(1'b1, 32'd80, 32'd5, 1'b0);
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL pass_early_done: got %b want 0", bus.done); end
    drive(1'b1, 32'd84, 32'd7, 1'b0);
    n_cmp++; if ({bus.done, bus.pass, bus.fail} !== {1'b1, m_state == 1, m_state == 2}) begin n_err++; $display("FAIL pass_status: got %b want 110", {bus.done, bus.pass, bus.fail}); end
    peek(32'd80, v);
    n_cmp++; if (v !== m_ram[20]) begin n_err++; $display("FAIL pass_ram80: got %0d want %0d", v, m_ram[20]); end
    peek(32'd84, v);
    n_cmp++; if (v !== m_ram[21]) begin n_err++; $display("FAIL pass_ram84: got %0d want %0d", v, m_ram[21]); end
    n_cmp++; if (bus.store_count !== m_cnt) begin n_err++; $display("FAIL pass_store_count: got %0d want %0d", bus.store_count, m_cnt); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if ({bus.log_valid, bus.log_addr, bus.log_data} !== {1'b1, m_q[0]}) begin n_err++; $display("FAIL pass_drain%0d: got %b %h want 1 %h", i, bus.log_valid, {bus.log_addr, bus.log_data}, m_q[0]); end
      drive(1'b0, 32'd0, 32'd0, 1'b1);
    end
    n_cmp++; if (bus.log_valid !== 1'b0) begin n_err++; $display("FAIL pass_drained: got %b want 0", bus.log_valid); end
  endtask

  task automatic test_fail();
    logic [31:0] v;
    do_reset();
    drive(1'b1, 32'd84, 32'd9, 1'b0);
    n_cmp++; if ({bus.done, bus.pass, bus.fail} !== 3'b101) begin n_err++; $display("FAIL fail_status: got %b want 101", {bus.done, bus.pass, bus.fail}); end
    drive(1'b1, 32'd84, 32'd7, 1'b0);
    n_cmp++; if ({bus.pass, bus.fail} !== 2'b01) begin n_err++; $display("FAIL fail_sticky: got %b want 01", {bus.pass, bus.fail}); end
    peek(32'd84, v);
    n_cmp++; if (v !== 32'd7) begin n_err++; $display("FAIL fail_ram84: got %0d want 7", v); end
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    n_cmp++; if ({bus.log_addr, bus.log_data} !== m_q[0]) begin n_err++; $display("FAIL fail_logged: got %h want %h", {bus.log_addr, bus.log_data}, m_q[0]); end
  endtask

  task automatic test_misaligned();
    logic [31:0] v;
    do_reset();
    drive(1'b1, 32'd82, 32'd1, 1'b0);
    n_cmp++; if (bus.fail !== 1'b1) begin n_err++; $display("FAIL mis_fail: got %b want 1", bus.fail); end
    peek(32'd80, v);
    n_cmp++; if (v !== m_ram[20]) begin n_err++; $display("FAIL mis_ram80: got %0d want %0d", v, m_ram[20]); end
    n_cmp++; if ({bus.log_addr, bus.log_data} !== {32'd82, 32'd1}) begin n_err++; $display("FAIL mis_log: got %h want %h", {bus.log_addr, bus.log_data}, {32'd82, 32'd1}); end
    drive(1'b1, 32'd4096, 32'd3, 1'b0);
    peek(32'd4096, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL oor_read: got %0d want 0", v); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) drive(1'b1, 32'd80, $urandom, 1'b0);
    n_cmp++; if ({bus.log_valid, bus.overflow} !== {1'b1, m_ovf}) begin n_err++; $display("FAIL ovf_full: got %b want %b", {bus.log_valid, bus.overflow}, {1'b1, m_ovf}); end
    drive(1'b1, 32'd80, $urandom, 1'b0);
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if ({bus.log_valid, bus.log_addr, bus.log_data} !== {1'b1, m_q[0]}) begin n_err++; $display("FAIL ovf_pop%0d: got %b %h want 1 %h", i, bus.log_valid, {bus.log_addr, bus.log_data}, m_q[0]); end
      drive(1'b0, 32'd0, 32'd0, 1'b1);
    end
    n_cmp++; if ({bus.log_valid, bus.log_addr, bus.log_data} !== 65'h0) begin n_err++; $display("FAIL ovf_empty: got %b %h want 0", bus.log_valid, {bus.log_addr, bus.log_data}); end
  endtask

  task automatic test_back_to_back();
    int pops;
    int want;
    logic [31:0] v;
    logic [31:0] keep;
    do_reset();
    for (int i = 0; i < 8; i++) drive(1'b1, 32'd80, $urandom, 1'b0);
    drive(1'b1, 32'd80, $urandom, 1'b1);
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL b2b_overflow: got %b want 0", bus.overflow); end
    want = m_q.size();
    pops = 0;
    while (bus.log_valid && pops < 20) begin
      n_cmp++; if ({bus.log_addr, bus.log_data} !== m_q[0]) begin n_err++; $display("FAIL b2b_pop%0d: got %h want %h", pops, {bus.log_addr, bus.log_data}, m_q[0]); end
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      pops++;
    end
    n_cmp++; if (pops !== want) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", pops, want); end
    keep = $urandom;
    drive(1'b1, 32'd80, keep, 1'b0);
    drive(1'b1, 32'd12, 32'd1, 1'b0);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    m_reset();
    n_cmp++; if ({bus.log_valid, bus.done, bus.fail, bus.store_count} !== 19'h0) begin n_err++; $display("FAIL midreset_state: got %b%b%b %0d want 0", bus.log_valid, bus.done, bus.fail, bus.store_count); end
    peek(32'd80, v);
    n_cmp++; if (v !== keep) begin n_err++; $display("FAIL midreset_ram: got %h want %h", v, keep); end
    @(negedge clk);
    drive(1'b1, 32'd84, 32'd7, 1'b0);
    n_cmp++; if (bus.pass !== 1'b1) begin n_err++; $display("FAIL midreset_run: got %b want 1", bus.pass); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, v, exp_v;
    bit we, rdy;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      if (c % 50 == 49) do_reset();
      case ($urandom % 6)
        0:       a = 32'd80;
        1:       a = 32'd84;
        2:       a = 32'd80 + ($urandom % 3) + 1;
        3:       a = 32'd4096 + ($urandom % 64) * 4;
        default: a = ($urandom % 64) * 4;
      endcase
      d   = $urandom_range(0, 9);
      we  = ($urandom % 3) != 0;
      rdy = ($urandom % 3) == 0;
      drive(we, a, d, rdy);
      n_cmp++; if ({bus.log_valid, bus.log_addr, bus.log_data} !== ((m_q.size() > 0) ? {1'b1, m_q[0]} : 65'h0)) begin n_err++; $display("FAIL rnd_log c%0d: got %b %h qsize %0d", c, bus.log_valid, {bus.log_addr, bus.log_data}, m_q.size()); end
      n_cmp++; if ({bus.overflow, bus.store_count} !== {m_ovf, m_cnt}) begin n_err++; $display("FAIL rnd_counters c%0d: got %b %0d want %b %0d", c, bus.overflow, bus.store_count, m_ovf, m_cnt); end
      n_cmp++; if ({bus.done, bus.pass, bus.fail} !== {m_state != 0, m_state == 1, m_state == 2}) begin n_err++; $display("FAIL rnd_status c%0d: got %b want state %0d", c, {bus.done, bus.pass, bus.fail}, m_state); end
      a = ($urandom % 64) * 4;
      if ($urandom % 4 == 0) a = a + 32'd256;
      if (a >= 32'd256 || m_known[a/4]) begin
        exp_v = (a >= 32'd256) ? 32'h0 : m_ram[a/4];
        peek(a, v);
        n_cmp++; if (v !== exp_v) begin n_err++; $display("FAIL rnd_read c%0d @%0d: got %h want %h", c, a, v, exp_v); end
      end
    end
  endtask

  initial begin
    bus.memwrite  = 1'b0;
    bus.dataadr   = 32'h0;
    bus.writedata = 32'h0;
    bus.log_ready = 1'b0;
    for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
    m_reset();
    @(negedge clk);
    test_reset();
    test_pass();
    test_fail();
    test_misaligned();
    test_overflow();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
